// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the nibble-serial 74181 ALU sequencer.
package alu_seq_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Index width for a nibble count, never narrower than one bit.
  function automatic int idx_width(input int nib);
    return (nib > 1) ? $clog2(nib) : 1;
  endfunction

endpackage

// File: rtl/alu_nibble_sequencer.sv
// Drives an external 4-bit 74181 slice once per nibble (LSN first), chaining carries.
// Optional macro ALU_SEQ_ZERO_EN adds a registered all-zero result flag.
module alu_nibble_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [3:0]       op_s,
  input  logic             op_m,
  input  logic             cin,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  output logic [3:0]       alu_s,
  output logic             alu_m,
  output logic             alu_cn,
  input  logic [3:0]       alu_f,
  input  logic             alu_cn4,
  input  logic             alu_equal,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
`ifdef ALU_SEQ_ZERO_EN
  output logic             zero,
`endif
  output logic             equal_all
);

  localparam int NIB   = WIDTH / NIBBLE_W;
  localparam int IDX_W = idx_width(NIB);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q;
  logic [WIDTH-1:0] a_q, b_q, shadow_q, assembled;
  logic [3:0]       s_q;
  logic             m_q, cin_q, carry_q, eq_acc_q;
  logic             last_nib;

  assign last_nib = (idx_q == LAST_IDX);
  assign alu_s    = s_q;
  assign alu_m    = m_q;
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);

  // NOTE: state and datapath registers use non-blocking (<=) so every flop
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every output of this block is given a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    alu_a     = '0;
    alu_b     = '0;
    alu_cn    = 1'b0;
    assembled = shadow_q;
    unique case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN: begin
        alu_a  = a_q[idx_q*NIBBLE_W +: NIBBLE_W];
        alu_b  = b_q[idx_q*NIBBLE_W +: NIBBLE_W];
        alu_cn = (idx_q == '0) ? cin_q : carry_q;
        assembled[idx_q*NIBBLE_W +: NIBBLE_W] = alu_f;
        if (last_nib) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Partial nibbles build up in shadow_q; result/cout/equal_all only change
  // on the final nibble so they stay stable from one done to the next.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      s_q       <= '0;
      m_q       <= 1'b0;
      cin_q     <= 1'b0;
      carry_q   <= 1'b0;
      eq_acc_q  <= 1'b0;
      shadow_q  <= '0;
      result    <= '0;
      cout      <= 1'b0;
      equal_all <= 1'b0;
`ifdef ALU_SEQ_ZERO_EN
      zero      <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            a_q      <= op_a;
            b_q      <= op_b;
            s_q      <= op_s;
            m_q      <= op_m;
            cin_q    <= cin;
            idx_q    <= '0;
            eq_acc_q <= 1'b1;
          end
        end
        RUN: begin
          shadow_q <= assembled;
          carry_q  <= alu_cn4;
          eq_acc_q <= eq_acc_q & alu_equal;
          if (last_nib) begin
            idx_q     <= '0;
            result    <= assembled;
            cout      <= alu_cn4;
            equal_all <= eq_acc_q & alu_equal;
`ifdef ALU_SEQ_ZERO_EN
            zero      <= (assembled == '0);
`endif
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
